mux_scan_ctrl: RTL and testbench
================================

# mux_scan_ctrl

Sequencer that sits directly upstream and downstream of the 16:1 single-bit mux (`in[15:0]`, `sel[3:0]`, `out`). It drives the mux select, walks it through all 16 channels, waits a programmable settle time per channel, samples the mux output, and assembles a 16-bit word. The word is presented on a valid/ready interface. It turns the combinational mux into a serial channel scanner.

## Interface
- `SETTLE`, default 1: idle cycles between a `sel_o` change and the sample of `mux_in`. Legal range is 0..15.
- `clk  in  1`: single clock; all logic on the rising edge.
- `rst_n  in  1`: reset, asynchronous, active-low. Asserts asynchronously; deassertion is synchronous to `clk` (externally synchronised).
- `start  in  1`: scan request, accepted only in IDLE.
- `abort  in  1`: synchronous cancel of a scan in progress.
- `mux_in  in  1`: connected to the mux `out`.
- `sel_o  out  4`: connected to the mux `sel`.
- `busy  out  1`: high in SETTLE and SAMPLE.
- `word_valid  out  1`: assembled word available.
- `word_ready  in  1`: consumer accepts the word.
- `word  out  16`: bit i is `mux_in` sampled while `sel_o == i`.

## Operation
- Reset values: IDLE, `sel_o`=0, settle counter=0, `busy`=0, `word_valid`=0, `word`=16'h0000.
- IDLE
  - On `start`=1: clear `word`, set `sel_o`=0, load counter with SETTLE.
  - Go to SETTLE, or straight to SAMPLE if SETTLE=0.
- SETTLE
  - Counter decrements each cycle.
  - When the counter reaches 1, the next state is SAMPLE (SETTLE wait cycles in total).
- SAMPLE (one cycle)
  - `word[sel_o]` <= `mux_in`.
  - If `sel_o`==15: go to DONE.
  - Otherwise: `sel_o` <= `sel_o`+1, reload counter, go to SETTLE (or stay in SAMPLE if SETTLE=0).
- DONE
  - `word_valid`=1; `word` and `sel_o` (=15) are held stable.
  - On `word_valid && word_ready`: go to IDLE, `sel_o` <= 0.
- `start` outside IDLE: ignored, not queued. This includes `start` in the same cycle as the DONE handshake; the requester must re-assert it.
- `abort` in SETTLE or SAMPLE
  - Go to IDLE next cycle with `sel_o`=0.
  - `word_valid` is never raised. The sample in an aborted SAMPLE cycle is discarded and `word` contents are unspecified.
- `abort` in IDLE or DONE: ignored. A word already valid is not withdrawn.
- `abort` and the final SAMPLE (`sel_o`=15) in the same cycle: abort wins.
- `rst_n` low mid-scan or in DONE: immediate return to reset values; the partial word is lost.
- `sel_o` increments only in SAMPLE, so there is no wrap from 15 to 0 inside a scan. `sel_o` returns to 0 only via IDLE entry.

## Timing
- Start accepted at edge 0. The first sample is taken at edge SETTLE+1.
- Each channel costs SETTLE+1 cycles. `word_valid` rises 16*(SETTLE+1) cycles after start acceptance: 32 for SETTLE=1, 16 for SETTLE=0.
- `mux_in` must be stable for the sample edge. The mux is combinational, so SETTLE=0 is legal when it is placed in the same clock domain.
- `word_valid` falls the cycle after the handshake. `busy` falls the cycle DONE is entered.
- Earliest next start acceptance is the first cycle in IDLE, one cycle after the handshake.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `mux_scan_pkg` holds:
  - state enum {IDLE, SETTLE, SAMPLE, DONE};
  - constants `NUM_CH`=16 and `SEL_W`=4;
  - settle counter width `CNT_W`=4.
- One sub-module, `scan_settle_timer`: loadable down-counter with a `load`/`expire` interface, instantiated once.
- The mux itself stays outside; the testbench instantiates both blocks.

## Test plan
- Mux `in`=16'hA5C3, SETTLE=1, `start` pulse, `word_ready`=1 → `word_valid` rises 32 cycles after acceptance with `word`=16'hA5C3, and `sel_o` steps 0..15 every 2 cycles.
- SETTLE=0, `in`=16'h8001 → `word`=16'h8001 valid 16 cycles after start; `sel_o` changes every cycle.
- `word_ready` held low 5 cycles in DONE; `start` pulsed at cycle 2 of that wait → `word` and `word_valid` stable throughout. `start` is ignored: after the handshake the FSM sits in IDLE and `busy`=0.
- `abort` asserted in the SAMPLE cycle with `sel_o`=7 → next cycle IDLE, `sel_o`=0, `busy`=0. `word_valid` never asserts. A following `start` yields a full correct word.
- `rst_n` pulsed low asynchronously (mid-cycle) at `sel_o`=10 → outputs take reset values immediately, without waiting for a clock edge. After release, a new scan of `in`=16'h1234 returns 16'h1234.
- `start` pulsed on cycle 5 of a scan → ignored; completion timing and word are unchanged.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared types and constants for the mux channel scanner
package mux_scan_pkg;

    localparam int NUM_CH = 16;
    localparam int SEL_W  = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } scan_state_e;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// rtl/mux_scan_ctrl_if.sv - control, mux and word handshake bundle of the scanner
interface mux_scan_ctrl_if;
    import mux_scan_pkg::*;

    logic              start;
    logic              abort;
    logic              mux_in;
    logic [SEL_W-1:0]  sel_o;
    logic              busy;
    logic              word_valid;
    logic              word_ready;
    logic [NUM_CH-1:0] word;

    // slave is the scanner, master is the requester/consumer side
    modport slave (
        input  start, abort, mux_in, word_ready,
        output sel_o, busy, word_valid, word
    );

    modport master (
        output start, abort, mux_in, word_ready,
        input  sel_o, busy, word_valid, word
    );

endinterface

// File: rtl/scan_settle_timer.sv
// rtl/scan_settle_timer.sv - loadable down-counter timing the per-channel settle wait
module scan_settle_timer
    import mux_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // a count of 1 marks the last wait cycle, so SETTLE=N yields exactly N waits
    assign expire = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - walks an external 16:1 mux select and assembles the sampled word
module mux_scan_ctrl
    import mux_scan_pkg::NUM_CH;
    import mux_scan_pkg::SEL_W;
    import mux_scan_pkg::CNT_W;
    import mux_scan_pkg::scan_state_e;
    import mux_scan_pkg::IDLE;
    import mux_scan_pkg::SAMPLE;
    import mux_scan_pkg::DONE;
#(
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_scan_ctrl_if.slave  bus
);

    // the SETTLE state literal is qualified because the parameter shares its name
    localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);
    localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(NUM_CH - 1);
    localparam scan_state_e      AFTER_LOAD = (SETTLE == 0) ? SAMPLE : mux_scan_pkg::SETTLE;

    scan_state_e       state_q, state_d;
    logic              load;
    logic              expire;
    logic [SEL_W-1:0]  sel_q;
    logic [NUM_CH-1:0] word_q;
    logic              busy_q;
    logic              valid_q;

    scan_settle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (SETTLE_CNT),
        .expire   (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = AFTER_LOAD;
                end
            end
            mux_scan_pkg::SETTLE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (expire) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                // abort outranks the final sample, so a cancelled scan never completes
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (sel_q == LAST_SEL) begin
                    state_d = DONE;
                end else begin
                    load    = 1'b1;
                    state_d = AFTER_LOAD;
                end
            end
            DONE: begin
                if (bus.word_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= '0;
            word_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            busy_q  <= (state_d == mux_scan_pkg::SETTLE) || (state_d == SAMPLE);
            valid_q <= (state_d == DONE);

            if (state_d == IDLE) begin
                sel_q <= '0;
            end else if (state_q == SAMPLE && state_d != DONE) begin
                sel_q <= sel_q + SEL_W'(1);
            end

            if (state_q == IDLE && bus.start) begin
                word_q <= '0;
            end else if (state_q == SAMPLE && !bus.abort) begin
                word_q[sel_q] <= bus.mux_in;
            end
        end
    end

    assign bus.sel_o      = sel_q;
    assign bus.word       = word_q;
    assign bus.busy       = busy_q;
    assign bus.word_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - self-checking bench for mux_scan_ctrl at SETTLE 0, 1 and 3
module tb_mux_scan_ctrl;

    typedef struct packed {
        logic        busy;
        logic        valid;
        logic [3:0]  sel;
        logic [15:0] word;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] mux_vec = 16'h0000;
    logic [2:0]  start_v = 3'b000;
    logic [2:0]  abort_v = 3'b000;
    logic [2:0]  ready_v = 3'b000;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    mux_scan_ctrl_if ifc0 ();
    mux_scan_ctrl_if ifc1 ();
    mux_scan_ctrl_if ifc2 ();

    // the 16:1 mux each scanner drives
    assign ifc0.start = start_v[0];
    assign ifc0.abort = abort_v[0];
    assign ifc0.word_ready = ready_v[0];
    assign ifc0.mux_in = mux_vec[ifc0.sel_o];
    assign ifc1.start = start_v[1];
    assign ifc1.abort = abort_v[1];
    assign ifc1.word_ready = ready_v[1];
    assign ifc1.mux_in = mux_vec[ifc1.sel_o];
    assign ifc2.start = start_v[2];
    assign ifc2.abort = abort_v[2];
    assign ifc2.word_ready = ready_v[2];
    assign ifc2.mux_in = mux_vec[ifc2.sel_o];

    mux_scan_ctrl #(.SETTLE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(ifc0.slave));
    mux_scan_ctrl #(.SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1.slave));
    mux_scan_ctrl #(.SETTLE(3)) dut2 (.clk(clk), .rst_n(rst_n), .bus(ifc2.slave));

    function automatic int s_of(int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
    endfunction

    function automatic obs_t snap(int d);
        case (d)
            0:       return {ifc0.busy, ifc0.word_valid, ifc0.sel_o, ifc0.word};
            1:       return {ifc1.busy, ifc1.word_valid, ifc1.sel_o, ifc1.word};
            default: return {ifc2.busy, ifc2.word_valid, ifc2.sel_o, ifc2.word};
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic chk_idle(int d, string tag);
        obs_t o;
        o = snap(d);
        chk({tag, " busy"}, o.busy, 0);
        chk({tag, " valid"}, o.valid, 0);
        chk({tag, " sel"}, o.sel, 0);
    endtask

    // Reference: after acceptance edge 0, sel = min(15, t/(S+1)); channel i is
    // sampled at edge (S+1)*(i+1); the word is valid from edge 16*(S+1).
    task automatic run_scan(int d, logic [15:0] vec, bit rnd, int ready_delay,
                            int ghost_at, int abort_at, int rst_at, int done_start_at);
        int          s;
        int          tt;
        int          ch;
        int          esel;
        logic [15:0] exp_w;
        obs_t        o;
        string       tg;
        s = s_of(d);
        tt = 16 * (s + 1);
        mux_vec = vec;
        exp_w = vec;
        ready_v[d] = (ready_delay == 0);
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
        for (int t = 0; t <= tt; t++) begin
            tg = $sformatf("d%0d t%0d", d, t);
            if (abort_at >= 0 && t == abort_at + 1) begin
                abort_v[d] = 1'b0;
                ready_v[d] = 1'b0;
                chk_idle(d, {tg, " abort"});
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    o = snap(d);
                    chk({tg, " abort no valid"}, o.valid, 0);
                end
                return;
            end
            if (rst_at >= 0 && t == rst_at) begin
                #3 rst_n = 1'b0;
                #1 o = snap(d);
                chk({tg, " async rst busy"}, o.busy, 0);
                chk({tg, " async rst valid"}, o.valid, 0);
                chk({tg, " async rst sel"}, o.sel, 0);
                chk({tg, " async rst word"}, o.word, 0);
                @(negedge clk);
                rst_n = 1'b1;
                ready_v[d] = 1'b0;
                return;
            end
            o = snap(d);
            esel = t / (s + 1);
            if (esel > 15) esel = 15;
            chk({tg, " sel"}, o.sel, esel);
            chk({tg, " busy"}, o.busy, t < tt);
            chk({tg, " valid"}, o.valid, t == tt);
            if (t == tt) chk({tg, " word"}, o.word, exp_w);
            start_v[d] = (t == ghost_at);
            abort_v[d] = (t == abort_at);
            if (rnd) mux_vec = 16'($urandom);
            if ((t + 1) % (s + 1) == 0 && (t + 1) / (s + 1) <= 16) begin
                ch = (t + 1) / (s + 1) - 1;
                exp_w[ch] = mux_vec[ch];
            end
            if (t < tt) @(negedge clk);
        end
        start_v[d] = 1'b0;
        for (int k = 0; k < ready_delay; k++) begin
            start_v[d] = (k == done_start_at);
            @(negedge clk);
            o = snap(d);
            tg = $sformatf("d%0d done%0d", d, k);
            chk({tg, " valid"}, o.valid, 1);
            chk({tg, " word"}, o.word, exp_w);
            chk({tg, " sel"}, o.sel, 15);
            chk({tg, " busy"}, o.busy, 0);
        end
        start_v[d] = 1'b0;
        ready_v[d] = 1'b1;
        @(negedge clk);
        ready_v[d] = 1'b0;
        chk_idle(d, $sformatf("d%0d post handshake", d));
        @(negedge clk);
        chk_idle(d, $sformatf("d%0d idle held", d));
    endtask

    initial begin
        obs_t o;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            o = snap(d);
            chk($sformatf("reset d%0d", d), {o.busy, o.valid, o.sel, o.word}, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        run_scan(1, 16'hA5C3, 1'b0, 0, -1, -1, -1, -1);
        run_scan(0, 16'h8001, 1'b0, 0, -1, -1, -1, -1);
        run_scan(1, 16'h3E71, 1'b0, 5, -1, -1, -1, 2);
        run_scan(1, 16'hA5C3, 1'b0, 0, -1, 15, -1, -1);
        run_scan(1, 16'h5A3C, 1'b0, 0, -1, -1, -1, -1);
        run_scan(0, 16'hFFFF, 1'b0, 0, -1, 15, -1, -1);
        run_scan(0, 16'h7FFE, 1'b0, 1, -1, -1, -1, -1);
        run_scan(1, 16'hA5C3, 1'b0, 0, -1, -1, 21, -1);
        run_scan(1, 16'h1234, 1'b0, 0, -1, -1, -1, -1);
        run_scan(2, 16'hBEEF, 1'b0, 0, 5, -1, -1, -1);
        for (int i = 0; i < 6; i++) begin
            run_scan(int'($urandom_range(2, 0)), 16'($urandom), 1'b1,
                     int'($urandom_range(3, 0)), int'($urandom_range(30, 1)), -1, -1, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
